// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester: FSM state encoding and default widths.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DefAddrWidth = 32;
  localparam int DefDataWidth = 32;
  localparam int DefSlaves    = 4;
  localparam int DefTimeout   = 255;

endpackage

// File: rtl/apb_requester_if.sv
// User request/response handshake plus APB bus signals of the requester.
interface apb_requester_if
  import apb_pkg::*;
#(
  parameter int AddrWidth = DefAddrWidth,
  parameter int DataWidth = DefDataWidth,
  parameter int Slaves    = DefSlaves,
  parameter int StrbWidth = DataWidth / 8
);

  logic                 ReqValid;
  logic                 ReqReady;
  logic                 ReqWrite;
  logic [AddrWidth-1:0] ReqAddr;
  logic [DataWidth-1:0] ReqData;
  logic [StrbWidth-1:0] ReqStrb;

  logic [Slaves-1:0]    PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [AddrWidth-1:0] PADDR;
  logic [DataWidth-1:0] PWDATA;
  logic [StrbWidth-1:0] PSTRB;
  logic [DataWidth-1:0] PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;

  logic                 RespValid;
  logic [DataWidth-1:0] RespData;
  logic                 RespErr;

  modport master (
    input  ReqValid, ReqWrite, ReqAddr, ReqData, ReqStrb,
    input  PRDATA, PREADY, PSLVERR,
    output ReqReady,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output RespValid, RespData, RespErr
  );

  modport slave (
    output ReqValid, ReqWrite, ReqAddr, ReqData, ReqStrb,
    output PRDATA, PREADY, PSLVERR,
    input  ReqReady,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  RespValid, RespData, RespErr
  );

endinterface

// File: rtl/apb_psel_decoder.sv
// One-hot completer select from the top address bits of the latched request.
module apb_psel_decoder #(
  parameter int Slaves = 4,
  parameter int SelW   = $clog2(Slaves)
) (
  input  logic              en_i,
  input  logic [SelW-1:0]   addr_top_i,
  output logic [Slaves-1:0] psel_o
);

  always_comb begin
    psel_o = '0;
    if (en_i) begin
      psel_o[addr_top_i] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_requester.sv
// APB requester: converts a valid/ready request into one SETUP/ACCESS transfer.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_requester
  import apb_pkg::*;
#(
  parameter int AddrWidth = DefAddrWidth,
  parameter int DataWidth = DefDataWidth,
  parameter int Slaves    = DefSlaves,
  parameter int StrbWidth = DataWidth / 8,
  parameter int Timeout   = DefTimeout
) (
  input logic             PCLK,
  input logic             reset,
  apb_requester_if.master bus
);

  localparam int SelW = $clog2(Slaves);

  if (Timeout < 1 || !(DataWidth == 8 || DataWidth == 16 || DataWidth == 32) ||
      Slaves < 2 || (1 << SelW) != Slaves) begin : g_bad_param
    $error("apb_requester: illegal parameter combination");
  end

  apb_state_e           state_q, state_d;
  logic                 latch_en;
  logic                 write_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] data_q;
  logic [StrbWidth-1:0] strb_q;
  logic                 resp_valid_q, resp_valid_d;
  logic [DataWidth-1:0] resp_data_q, resp_data_d;
  logic                 resp_err_q, resp_err_d;
  logic                 timeout_hit;

`ifdef APB_TIMEOUT_EN
  localparam int CntW = (Timeout > 1) ? $clog2(Timeout) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Loaded in SETUP so it reaches zero in the Timeout-th ACCESS cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP) begin
      cnt_d = CntW'(Timeout - 1);
    end else if (state_q == ACCESS && cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit = (state_q == ACCESS) && (cnt_q == '0);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    latch_en     = 1'b0;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.ReqValid) begin
          latch_en = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (bus.PREADY) begin
          resp_valid_d = 1'b1;
          resp_data_d  = write_q ? '0 : bus.PRDATA;
          resp_err_d   = bus.PSLVERR;
          state_d      = IDLE;
        end else if (timeout_hit) begin
          resp_valid_d = 1'b1;
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      strb_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      if (latch_en) begin
        write_q <= bus.ReqWrite;
        addr_q  <= bus.ReqAddr;
        data_q  <= bus.ReqData;
        strb_q  <= bus.ReqStrb;
      end
    end
  end

  apb_psel_decoder #(
    .Slaves (Slaves),
    .SelW   (SelW)
  ) u_psel_decoder (
    .en_i       (state_q != IDLE),
    .addr_top_i (addr_q[AddrWidth-1 -: SelW]),
    .psel_o     (bus.PSEL)
  );

  assign bus.ReqReady  = (state_q == IDLE);
  assign bus.PENABLE   = (state_q == ACCESS);
  assign bus.PWRITE    = write_q;
  assign bus.PADDR     = addr_q;
  // Reads never expose stale write data or strobes on the bus.
  assign bus.PWDATA    = write_q ? data_q : '0;
  assign bus.PSTRB     = write_q ? strb_q : '0;
  assign bus.RespValid = resp_valid_q;
  assign bus.RespData  = resp_data_q;
  assign bus.RespErr   = resp_err_q;

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: directed scenarios plus randomized traffic vs. a transaction model.
module tb_apb_requester;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int SW = 4;
  localparam int TO = 8;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_requester_if #(.AddrWidth(AW), .DataWidth(DW), .Slaves(NS), .StrbWidth(SW)) bus();

  apb_requester #(
    .AddrWidth (AW),
    .DataWidth (DW),
    .Slaves    (NS),
    .StrbWidth (SW),
    .Timeout   (TO)
  ) dut (
    .PCLK  (clk),
    .reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one outstanding request, tracked by cycles since acceptance.
  bit          m_busy;
  int          m_age;
  int          m_waits;
  logic        m_write;
  logic [31:0] m_addr, m_data;
  logic [3:0]  m_strb;
  bit          m_rv;
  logic [31:0] m_rd;
  logic        m_re;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_rv   = 1'b0;
      m_age  = 0;
    end else begin
      m_rv = 1'b0;
      if (!m_busy) begin
        if (bus.ReqValid) begin
          m_busy  = 1'b1;
          m_age   = 1;
          m_waits = 0;
          m_write = bus.ReqWrite;
          m_addr  = bus.ReqAddr;
          m_data  = bus.ReqData;
          m_strb  = bus.ReqStrb;
        end
      end else if (m_age == 1) begin
        m_age = 2;
      end else begin
        m_waits++;
        if (bus.PREADY) begin
          m_rv   = 1'b1;
          m_rd   = m_write ? 32'h0 : bus.PRDATA;
          m_re   = bus.PSLVERR;
          m_busy = 1'b0;
        end else if (TO_EN && m_waits == TO) begin
          m_rv   = 1'b1;
          m_rd   = 32'h0;
          m_re   = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_ReqReady", 64'(bus.ReqReady), 64'(!m_busy));
    chk("m_PSEL", 64'(bus.PSEL), m_busy ? 64'(4'b0001 << m_addr[31:30]) : 64'h0);
    chk("m_PENABLE", 64'(bus.PENABLE), 64'(m_busy && m_age >= 2));
    chk("m_RespValid", 64'(bus.RespValid), 64'(m_rv));
    if (m_busy) begin
      chk("m_PADDR", 64'(bus.PADDR), 64'(m_addr));
      chk("m_PWRITE", 64'(bus.PWRITE), 64'(m_write));
      chk("m_PWDATA", 64'(bus.PWDATA), m_write ? 64'(m_data) : 64'h0);
      chk("m_PSTRB", 64'(bus.PSTRB), m_write ? 64'(m_strb) : 64'h0);
    end
    if (m_rv) begin
      chk("m_RespData", 64'(bus.RespData), 64'(m_rd));
      chk("m_RespErr", 64'(bus.RespErr), 64'(m_re));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && !bus.ReqReady; i++) tick();
    chk("wait_idle", 64'(bus.ReqReady), 64'h1);
  endtask

  task automatic offer(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.ReqValid = 1'b1;
    bus.ReqWrite = wr;
    bus.ReqAddr  = a;
    bus.ReqData  = d;
    bus.ReqStrb  = s;
  endtask

  initial begin
    rst = 1'b1;
    bus.ReqValid = 1'b0;
    bus.ReqWrite = 1'b0;
    bus.ReqAddr  = '0;
    bus.ReqData  = '0;
    bus.ReqStrb  = '0;
    bus.PRDATA   = '0;
    bus.PREADY   = 1'b0;
    bus.PSLVERR  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("rst_PSEL", 64'(bus.PSEL), 64'h0);
    chk("rst_PENABLE", 64'(bus.PENABLE), 64'h0);
    chk("rst_PWRITE", 64'(bus.PWRITE), 64'h0);
    chk("rst_PADDR", 64'(bus.PADDR), 64'h0);
    chk("rst_PWDATA", 64'(bus.PWDATA), 64'h0);
    chk("rst_PSTRB", 64'(bus.PSTRB), 64'h0);
    chk("rst_RespValid", 64'(bus.RespValid), 64'h0);
    chk("rst_RespData", 64'(bus.RespData), 64'h0);
    chk("rst_RespErr", 64'(bus.RespErr), 64'h0);
    chk("rst_ReqReady", 64'(bus.ReqReady), 64'h1);

    // Zero-wait read
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'hDEAD_BEEF;
    offer(1'b0, 32'h4000_0010, 32'h5555_AAAA, 4'hF);
    tick();
    bus.ReqValid = 1'b0;
    chk("rd_setup_PSEL", 64'(bus.PSEL), 64'h2);
    chk("rd_setup_PENABLE", 64'(bus.PENABLE), 64'h0);
    chk("rd_setup_PWDATA", 64'(bus.PWDATA), 64'h0);
    chk("rd_setup_PSTRB", 64'(bus.PSTRB), 64'h0);
    chk("rd_setup_ReqReady", 64'(bus.ReqReady), 64'h0);
    tick();
    chk("rd_access_PENABLE", 64'(bus.PENABLE), 64'h1);
    chk("rd_access_PSEL", 64'(bus.PSEL), 64'h2);
    tick();
    chk("rd_RespValid", 64'(bus.RespValid), 64'h1);
    chk("rd_RespData", 64'(bus.RespData), 64'hDEAD_BEEF);
    chk("rd_RespErr", 64'(bus.RespErr), 64'h0);
    tick();
    chk("rd_RespValid_drop", 64'(bus.RespValid), 64'h0);

    // Write with three wait states
    wait_idle();
    bus.PREADY = 1'b0;
    offer(1'b1, 32'hC000_0004, 32'h1234_5678, 4'b0101);
    tick();
    bus.ReqValid = 1'b0;
    chk("wr_setup_PSEL", 64'(bus.PSEL), 64'h8);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) bus.PREADY = 1'b1;
      chk("wr_access_PSEL", 64'(bus.PSEL), 64'h8);
      chk("wr_access_PENABLE", 64'(bus.PENABLE), 64'h1);
      chk("wr_access_PSTRB", 64'(bus.PSTRB), 64'h5);
      chk("wr_access_PWDATA", 64'(bus.PWDATA), 64'h1234_5678);
      chk("wr_no_early_resp", 64'(bus.RespValid), 64'h0);
    end
    tick();
    chk("wr_RespValid", 64'(bus.RespValid), 64'h1);
    chk("wr_RespData", 64'(bus.RespData), 64'h0);
    chk("wr_RespErr", 64'(bus.RespErr), 64'h0);

    // Read with slave error
    wait_idle();
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b1;
    bus.PRDATA  = 32'h0BAD_F00D;
    offer(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    tick();
    bus.ReqValid = 1'b0;
    chk("err_setup_PSEL", 64'(bus.PSEL), 64'h1);
    tick();
    tick();
    chk("err_RespValid", 64'(bus.RespValid), 64'h1);
    chk("err_RespErr", 64'(bus.RespErr), 64'h1);
    chk("err_RespData", 64'(bus.RespData), 64'h0BAD_F00D);
    bus.PSLVERR = 1'b0;
    tick();
    chk("err_RespValid_drop", 64'(bus.RespValid), 64'h0);

    // Reset during ACCESS
    wait_idle();
    bus.PREADY = 1'b0;
    offer(1'b0, 32'h8000_0000, 32'h0, 4'h0);
    tick();
    bus.ReqValid = 1'b0;
    tick();
    chk("rstmid_PENABLE_before", 64'(bus.PENABLE), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_PSEL", 64'(bus.PSEL), 64'h0);
    chk("rstmid_PENABLE", 64'(bus.PENABLE), 64'h0);
    @(posedge clk);
    #3 rst = 1'b0;
    bus.PREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstmid_no_resp", 64'(bus.RespValid), 64'h0);
      chk("rstmid_ReqReady", 64'(bus.ReqReady), 64'h1);
    end

    // PREADY held low: timeout or indefinite wait
    bus.PREADY = 1'b0;
    offer(1'b0, 32'h4000_0000, 32'h0, 4'h0);
    tick();
    bus.ReqValid = 1'b0;
`ifdef APB_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      tick();
      chk("to_waiting_PENABLE", 64'(bus.PENABLE), 64'h1);
      chk("to_waiting_RespValid", 64'(bus.RespValid), 64'h0);
    end
    tick();
    chk("to_RespValid", 64'(bus.RespValid), 64'h1);
    chk("to_RespErr", 64'(bus.RespErr), 64'h1);
    chk("to_RespData", 64'(bus.RespData), 64'h0);
`else
    repeat (100) tick();
    chk("nto_PENABLE", 64'(bus.PENABLE), 64'h1);
    chk("nto_PSEL", 64'(bus.PSEL), 64'h2);
    chk("nto_RespValid", 64'(bus.RespValid), 64'h0);
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'hCAFE_0001;
    tick();
    chk("nto_RespValid", 64'(bus.RespValid), 64'h1);
    chk("nto_RespData", 64'(bus.RespData), 64'hCAFE_0001);
`endif

    // Back-to-back with ReqValid held high
    bus.PREADY = 1'b1;
    wait_idle();
    offer(1'b1, 32'h8000_0100, 32'hAAAA_0001, 4'b0011);
    tick();
    offer(1'b0, 32'h4000_0200, 32'h0, 4'h0);
    tick();
    chk("b2b_A_PADDR", 64'(bus.PADDR), 64'h8000_0100);
    chk("b2b_A_PWRITE", 64'(bus.PWRITE), 64'h1);
    tick();
    chk("b2b_A_RespValid", 64'(bus.RespValid), 64'h1);
    chk("b2b_A_ReqReady", 64'(bus.ReqReady), 64'h1);
    tick();
    bus.ReqValid = 1'b0;
    chk("b2b_B_PSEL", 64'(bus.PSEL), 64'h2);
    chk("b2b_B_PENABLE", 64'(bus.PENABLE), 64'h0);
    chk("b2b_B_PADDR", 64'(bus.PADDR), 64'h4000_0200);
    chk("b2b_B_PWRITE", 64'(bus.PWRITE), 64'h0);
    tick();
    tick();
    chk("b2b_B_RespValid", 64'(bus.RespValid), 64'h1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.ReqValid = 1'($urandom_range(0, 1));
      bus.ReqWrite = 1'($urandom_range(0, 1));
      bus.ReqAddr  = $urandom;
      bus.ReqData  = $urandom;
      bus.ReqStrb  = 4'($urandom_range(0, 15));
      bus.PREADY   = ($urandom_range(0, 9) < 4);
      bus.PRDATA   = $urandom;
      bus.PSLVERR  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      tick();
    end
    bus.ReqValid = 1'b0;
    bus.PREADY   = 1'b1;
    wait_idle();
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
